// File: rtl/clk_rst_seq.sv
// Staged reset sequencer. It qualifies the clock generator's lock flag, then
// releases the reset outputs one stage at a time and raises ready.
module clk_rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_STABLE = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_loss_cnt,
  output logic [1:0]            state
);

  localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sync_q1, locked_s;
  logic [SW-1:0]         stable_q, stable_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_out_d;
  logic                  ready_d;
  logic [7:0]            cnt_d;

  // locked is asynchronous to clk, so only locked_s is used past this point
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked;
      locked_s <= sync_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_LOCK;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q      <= '0;
      gap_q         <= '0;
      idx_q         <= '0;
      rst_out       <= '1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      stable_q      <= stable_d;
      gap_q         <= gap_d;
      idx_q         <= idx_d;
      rst_out       <= rst_out_d;
      ready         <= ready_d;
      lock_loss_cnt <= cnt_d;
    end
  end

  // Stages drop low-bit first, so each release is a left shift of rst_out;
  // idx_q holds the bit that the next release will drop.
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rst_out_d = rst_out;
    ready_d   = ready;
    cnt_d     = lock_loss_cnt;
    case (state_q)
      WAIT_LOCK: begin
        if (!locked_s || soft_rst_req) begin
          stable_d = '0;
        end else if (stable_q == SW'(LOCK_STABLE - 1)) begin
          stable_d  = '0;
          gap_d     = '0;
          idx_d     = IW'(1);
          rst_out_d = rst_out << 1;
          if (NUM_STAGES == 1) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!locked_s || soft_rst_req) begin
          state_d   = WAIT_LOCK;
          stable_d  = '0;
          gap_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (!locked_s && lock_loss_cnt != 8'hFF) cnt_d = lock_loss_cnt + 8'd1;
        end else if (state_q == RELEASE) begin
          if (gap_q == GW'(STAGE_GAP - 1)) begin
            gap_d     = '0;
            rst_out_d = rst_out << 1;
            idx_d     = idx_q + 1'b1;
            if (idx_q == IW'(NUM_STAGES - 1)) begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with default parameters; the edge numbers
// below count from the first edge that samples a new level of locked.
module tb_clk_rst_seq;

  logic       clk = 1'b0;
  logic       rst, locked, soft_rst_req;
  logic [2:0] rst_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  clk_rst_seq dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Drive inputs, then run the given number of edges; sampling is 1ns past the edge
  task automatic applyStimulus(input logic l, input logic s, input logic r, input int edges);
    locked       = l;
    soft_rst_req = s;
    rst          = r;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [2:0] exp_rst, input logic exp_ready,
                            input logic [1:0] exp_state, input logic [7:0] exp_cnt);
    checkOutput({tag, ".rst_out"}, 32'(rst_out), 32'(exp_rst));
    checkOutput({tag, ".ready"}, 32'(ready), 32'(exp_ready));
    checkOutput({tag, ".state"}, 32'(state), 32'(exp_state));
    checkOutput({tag, ".lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(exp_cnt));
  endtask

  initial begin
    // Reset held for three edges
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkState("reset", 3'b111, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);

    // Clean power-up release: 17/25/33
    applyStimulus(1'b1, 1'b0, 1'b0, 17);
    checkState("pwr.e16", 3'b111, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkState("pwr.e17", 3'b110, 1'b0, 2'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkState("pwr.e24", 3'b110, 1'b0, 2'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkState("pwr.e25", 3'b100, 1'b0, 2'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkState("pwr.e32", 3'b100, 1'b0, 2'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkState("pwr.e33", 3'b000, 1'b1, 2'd2, 8'd0);

    // Lock loss in RUN takes effect after edge 2
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkState("loss.e1", 3'b000, 1'b1, 2'd2, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkState("loss.e2", 3'b111, 1'b0, 2'd0, 8'd1);

    // Re-lock repeats the full sequence
    applyStimulus(1'b1, 1'b0, 1'b0, 18);
    checkState("relock.e17", 3'b110, 1'b0, 2'd1, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    checkState("relock.e25", 3'b100, 1'b0, 2'd1, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    checkState("relock.e33", 3'b000, 1'b1, 2'd2, 8'd1);

    // Soft reset during RELEASE; requalification needs 16 further high samples
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkState("loss2", 3'b111, 1'b0, 2'd0, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 18);
    checkState("soft.pre", 3'b110, 1'b0, 2'd1, 8'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkState("soft.e18", 3'b111, 1'b0, 2'd0, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 15);
    checkState("soft.e33", 3'b111, 1'b0, 2'd0, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkState("soft.e34", 3'b110, 1'b0, 2'd1, 8'd2);

    // Loss in RELEASE, then a one-cycle glitch at edge 10 while in WAIT_LOCK
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkState("loss3", 3'b111, 1'b0, 2'd0, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 17);
    checkState("glitch.e27", 3'b111, 1'b0, 2'd0, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkState("glitch.e28", 3'b110, 1'b0, 2'd1, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 16);
    checkState("glitch.e44", 3'b000, 1'b1, 2'd2, 8'd3);

    // Soft request coinciding with the first low locked_s in RUN counts once
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkState("both", 3'b111, 1'b0, 2'd0, 8'd4);

    // Repeated full lock / loss cycles saturate the counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 34);
      applyStimulus(1'b0, 1'b0, 1'b0, 3);
      if (i == 0) checkState("sat.first", 3'b111, 1'b0, 2'd0, 8'd5);
    end
    checkState("sat.end", 3'b111, 1'b0, 2'd0, 8'd255);

    // rst mid-RELEASE restores reset values and clears the count
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    checkState("mid.pre", 3'b110, 1'b0, 2'd1, 8'd255);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkState("mid.rst", 3'b111, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 17);
    checkState("post.e16", 3'b111, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkState("post.e17", 3'b110, 1'b0, 2'd1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
